hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_if.sv | 49 ++++
 rtl/hazard_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// The datapath owns the master side; hazard_ctrl attaches through the slave modport.
interface hazard_ctrl_if;
  logic [4:0]  id_rs1_i;
  logic [4:0]  id_rs2_i;
  logic        id_use_rs1_i;
  logic        id_use_rs2_i;
  logic [4:0]  ex_rd_i;
  logic        ex_rd_wren_i;
  logic        ex_mem_read_i;
  logic        ex_branch_taken_i;
  logic        mem_req_i;
  logic        mem_ack_i;
  logic        halt_req_i;
  logic        resume_i;

  logic        pc_en_o;
  logic        ifid_en_o;
  logic        idex_en_o;
  logic        exmem_en_o;
  logic        ifid_flush_o;
  logic        idex_flush_o;
  logic        memwb_bubble_o;
  logic [1:0]  state_o;
  logic        err_o;
  logic [15:0] stall_cnt_o;
  logic [15:0] flush_cnt_o;

  // Handshake: there is no valid/ready pair here. Every input is sampled
  // as a level each rising edge; every output is a level valid for the
  // current cycle, with mem_ack_i completing a mem_req_i in the same cycle.
  modport master (
    output id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
    output ex_rd_i, ex_rd_wren_i, ex_mem_read_i, ex_branch_taken_i,
    output mem_req_i, mem_ack_i, halt_req_i, resume_i,
    input  pc_en_o, ifid_en_o, idex_en_o, exmem_en_o,
    input  ifid_flush_o, idex_flush_o, memwb_bubble_o,
    input  state_o, err_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
    input  ex_rd_i, ex_rd_wren_i, ex_mem_read_i, ex_branch_taken_i,
    input  mem_req_i, mem_ack_i, halt_req_i, resume_i,
    output pc_en_o, ifid_en_o, idex_en_o, exmem_en_o,
    output ifid_flush_o, idex_flush_o, memwb_bubble_o,
    output state_o, err_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use stalls, branch flushes,
// memory-wait freeze with timeout, and a debug halt that drains ID/EX/MEM first.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned DRAIN_LEN   = 3
) (
  input  logic         clk_i,
  input  logic         reset_i,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALTED   = 2'd3
  } state_e;

  localparam logic [7:0]  WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);
  localparam logic [7:0]  DRAIN_INIT = 8'(DRAIN_LEN);
  localparam logic [15:0] CNT_MAX    = 16'hFFFF;

  state_e      state_q, state_d;
  logic        err_q, err_d;
  logic        halt_pend_q, halt_pend_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [7:0]  drain_cnt_q, drain_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  logic freeze;
  logic loaduse;
  logic branch;
  logic halted;
  logic loaduse_live;
  logic branch_flush;
  logic advance;
  logic halt_wanted;

  // Hazard detection from the current stage contents.
  always_comb begin
    freeze  = hz.mem_req_i & ~hz.mem_ack_i;
    loaduse = hz.ex_mem_read_i & hz.ex_rd_wren_i & (hz.ex_rd_i != 5'd0) &
              ((hz.id_use_rs1_i & (hz.id_rs1_i == hz.ex_rd_i)) |
               (hz.id_use_rs2_i & (hz.id_rs2_i == hz.ex_rd_i)));
    branch  = hz.ex_branch_taken_i;
    halted  = (state_q == ST_HALTED);
    // A taken branch squashes the dependent ID instruction, so its
    // load-use hazard never materialises.
    loaduse_live = loaduse & ~branch & ~freeze & ~halted;
    branch_flush = branch & ~freeze & ~halted;
    advance      = ~freeze & ~(loaduse & ~branch) & ~halted;
    halt_wanted  = hz.halt_req_i | halt_pend_q;
  end

  // Stage control decode, highest priority first.
  always_comb begin
    hz.pc_en_o        = 1'b1;
    hz.ifid_en_o      = 1'b1;
    hz.idex_en_o      = 1'b1;
    hz.exmem_en_o     = 1'b1;
    hz.ifid_flush_o   = 1'b0;
    hz.idex_flush_o   = 1'b0;
    hz.memwb_bubble_o = 1'b0;
    if (halted || freeze) begin
      hz.pc_en_o        = 1'b0;
      hz.ifid_en_o      = 1'b0;
      hz.idex_en_o      = 1'b0;
      hz.exmem_en_o     = 1'b0;
      hz.memwb_bubble_o = 1'b1;
    end else if (branch) begin
      hz.ifid_flush_o = 1'b1;
      hz.idex_flush_o = 1'b1;
    end else if (loaduse) begin
      hz.pc_en_o      = 1'b0;
      hz.ifid_en_o    = 1'b0;
      hz.idex_flush_o = 1'b1;
    end else if (state_q == ST_DRAIN) begin
      hz.pc_en_o      = 1'b0;
      hz.ifid_flush_o = 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    wait_cnt_d  = wait_cnt_q;
    drain_cnt_d = drain_cnt_q;
    halt_pend_d = halt_pend_q | (hz.halt_req_i & ~halted);

    unique case (state_q)
      ST_RUN: begin
        if (freeze) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = 8'd1;
        end else if (halt_wanted) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = DRAIN_INIT;
          halt_pend_d = 1'b0;
        end
      end
      ST_MEM_WAIT: begin
        if (freeze) begin
          if (wait_cnt_q == WAIT_LIMIT) begin
            state_d    = ST_HALTED;
            err_d      = 1'b1;
            wait_cnt_d = 8'd0;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end else begin
          wait_cnt_d = 8'd0;
          if (halt_wanted) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = DRAIN_INIT;
            halt_pend_d = 1'b0;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_DRAIN: begin
        if (advance) begin
          if (drain_cnt_q <= 8'd1) begin
            state_d     = ST_HALTED;
            drain_cnt_d = 8'd0;
          end else begin
            drain_cnt_d = drain_cnt_q - 8'd1;
          end
        end
      end
      ST_HALTED: begin
        if (hz.resume_i && !err_q) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Saturating performance counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((freeze && !halted) || loaduse_live) begin
      if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (branch_flush) begin
      if (flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_RUN;
      err_q       <= 1'b0;
      halt_pend_q <= 1'b0;
      wait_cnt_q  <= 8'd0;
      drain_cnt_q <= 8'd0;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      halt_pend_q <= halt_pend_d;
      wait_cnt_q  <= wait_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.state_o     = state_q;
  assign hz.err_o       = err_q;
  assign hz.stall_cnt_o = stall_cnt_q;
  assign hz.flush_cnt_o = flush_cnt_q;

  // A halted pipeline must never move any stage register.
  a_halted_frozen : assert property (@(posedge clk_i) disable iff (reset_i)
    (state_q == ST_HALTED) |-> !(hz.pc_en_o | hz.ifid_en_o | hz.idex_en_o | hz.exmem_en_o));

  a_err_only_halted : assert property (@(posedge clk_i) disable iff (reset_i)
    err_q |-> (state_q == ST_HALTED));

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// traffic, all compared against a behavioural model of the controller rules.
module tb_hazard_ctrl;
  localparam int MEM_TIMEOUT = 64;
  localparam int DRAIN_LEN   = 3;

  logic clk_i;
  logic reset_i;
  hazard_ctrl_if hz();

  hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .DRAIN_LEN(DRAIN_LEN)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .hz      (hz)
  );

  // ---------------- clock / reset ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no end of test, required end before limit");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [1:0] exp_q[$];

  // Behavioural model: mode 0 run, 1 waiting on memory, 2 draining, 3 halted.
  int m_state;
  bit m_err;
  bit m_pend;
  int m_frozen;
  int m_left;
  int m_stall;
  int m_flush;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit id_reads(input logic [4:0] r);
    return (hz.id_use_rs1_i && hz.id_rs1_i == r) || (hz.id_use_rs2_i && hz.id_rs2_i == r);
  endfunction

  function automatic bit m_freeze();
    return hz.mem_req_i && !hz.mem_ack_i;
  endfunction

  function automatic bit m_loaduse();
    return hz.ex_mem_read_i && hz.ex_rd_wren_i && (hz.ex_rd_i != 5'd0) && id_reads(hz.ex_rd_i);
  endfunction

  // {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_bubble}
  function automatic logic [6:0] model_ctrl();
    if (m_state == 3 || m_freeze())   return 7'b0000_001;
    if (hz.ex_branch_taken_i)          return 7'b1111_110;
    if (m_loaduse())                   return 7'b0011_010;
    if (m_state == 2)                  return 7'b0111_100;
    return 7'b1111_000;
  endfunction

  task automatic model_reset();
    m_state = 0; m_err = 0; m_pend = 0; m_frozen = 0; m_left = 0;
    m_stall = 0; m_flush = 0;
  endtask

  task automatic model_update();
    bit fr, lu, br, halted, moved, want_halt;
    fr = m_freeze();
    lu = m_loaduse();
    br = hz.ex_branch_taken_i;
    halted    = (m_state == 3);
    moved     = !halted && !fr && !(lu && !br);
    want_halt = hz.halt_req_i || m_pend;
    if (!halted && (fr || (lu && !br)) && m_stall < 65535) m_stall++;
    if (!halted && br && !fr && m_flush < 65535) m_flush++;
    if (!halted && hz.halt_req_i) m_pend = 1;
    case (m_state)
      0: begin
        if (fr) begin m_state = 1; m_frozen = 1; end
        else if (want_halt) begin m_state = 2; m_left = DRAIN_LEN; m_pend = 0; end
      end
      1: begin
        if (fr) begin
          m_frozen++;
          if (m_frozen == MEM_TIMEOUT) begin m_state = 3; m_err = 1; end
        end else if (want_halt) begin
          m_state = 2; m_left = DRAIN_LEN; m_pend = 0;
        end else begin
          m_state = 0;
        end
      end
      2: begin
        if (moved) begin
          m_left--;
          if (m_left == 0) m_state = 3;
        end
      end
      default: begin
        if (hz.resume_i && !m_err) m_state = 0;
      end
    endcase
  endtask

  task automatic check_outputs();
    check("ctrl", {hz.pc_en_o, hz.ifid_en_o, hz.idex_en_o, hz.exmem_en_o,
                   hz.ifid_flush_o, hz.idex_flush_o, hz.memwb_bubble_o}, model_ctrl());
    check("state", hz.state_o, m_state);
    check("err", hz.err_o, m_err);
    check("stall_cnt", hz.stall_cnt_o, m_stall);
    check("flush_cnt", hz.flush_cnt_o, m_flush);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    hz.id_rs1_i = 5'd0; hz.id_rs2_i = 5'd0;
    hz.id_use_rs1_i = 1'b0; hz.id_use_rs2_i = 1'b0;
    hz.ex_rd_i = 5'd0; hz.ex_rd_wren_i = 1'b0; hz.ex_mem_read_i = 1'b0;
    hz.ex_branch_taken_i = 1'b0;
    hz.mem_req_i = 1'b0; hz.mem_ack_i = 1'b0;
    hz.halt_req_i = 1'b0; hz.resume_i = 1'b0;
  endtask

  task automatic drive_random();
    hz.mem_req_i         = ($urandom_range(0, 99) < 30);
    hz.mem_ack_i         = hz.mem_req_i && ($urandom_range(0, 1) == 1);
    hz.ex_branch_taken_i = ($urandom_range(0, 99) < 15);
    hz.ex_mem_read_i     = ($urandom_range(0, 99) < 40);
    hz.ex_rd_wren_i      = ($urandom_range(0, 99) < 80);
    hz.ex_rd_i           = 5'($urandom_range(0, 3));
    hz.id_rs1_i          = 5'($urandom_range(0, 3));
    hz.id_rs2_i          = 5'($urandom_range(0, 3));
    hz.id_use_rs1_i      = ($urandom_range(0, 1) == 1);
    hz.id_use_rs2_i      = ($urandom_range(0, 1) == 1);
    hz.halt_req_i        = ($urandom_range(0, 99) < 4);
    hz.resume_i          = ($urandom_range(0, 99) < 15);
  endtask

  // Called at a falling edge with inputs already applied.
  task automatic step();
    #1;
    check_outputs();
    model_update();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Asserted mid low phase so the immediate (clockless) effect is visible.
  task automatic apply_reset();
    #3 reset_i = 1'b1;
    #1;
    check("rst_async_state", hz.state_o, 2'd0);
    check("rst_async_err", hz.err_o, 1'b0);
    check("rst_async_stall", hz.stall_cnt_o, 16'd0);
    check("rst_async_flush", hz.flush_cnt_o, 16'd0);
    model_reset();
    @(posedge clk_i);
    @(negedge clk_i);
    #1;
    check_outputs();
    drive_idle();
    reset_i = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    reset_i = 1'b1;
    drive_idle();
    model_reset();
    repeat (2) @(negedge clk_i);
    #1;
    check_outputs();
    reset_i = 1'b0;
    @(negedge clk_i);

    // Load-use: EX lw x5, ID add x6,x5,x1.
    hz.ex_mem_read_i = 1'b1; hz.ex_rd_wren_i = 1'b1; hz.ex_rd_i = 5'd5;
    hz.id_use_rs1_i = 1'b1; hz.id_rs1_i = 5'd5; hz.id_use_rs2_i = 1'b1; hz.id_rs2_i = 5'd1;
    #1;
    check("lu_pc_en", hz.pc_en_o, 1'b0);
    check("lu_ifid_en", hz.ifid_en_o, 1'b0);
    check("lu_idex_flush", hz.idex_flush_o, 1'b1);
    step();
    check("lu_stall_cnt", hz.stall_cnt_o, 16'd1);

    // Load into x0 never stalls.
    hz.ex_rd_i = 5'd0; hz.id_rs1_i = 5'd0;
    #1;
    check("x0_pc_en", hz.pc_en_o, 1'b1);
    check("x0_ifid_en", hz.ifid_en_o, 1'b1);
    step();
    check("x0_stall_cnt", hz.stall_cnt_o, 16'd1);

    // Branch taken overrides a same-cycle load-use.
    apply_reset();
    @(negedge clk_i);
    hz.ex_mem_read_i = 1'b1; hz.ex_rd_wren_i = 1'b1; hz.ex_rd_i = 5'd7;
    hz.id_use_rs1_i = 1'b1; hz.id_rs1_i = 5'd7; hz.ex_branch_taken_i = 1'b1;
    #1;
    check("br_pc_en", hz.pc_en_o, 1'b1);
    check("br_ifid_flush", hz.ifid_flush_o, 1'b1);
    check("br_idex_flush", hz.idex_flush_o, 1'b1);
    step();
    check("br_flush_cnt", hz.flush_cnt_o, 16'd1);
    check("br_stall_cnt", hz.stall_cnt_o, 16'd0);
    drive_idle();

    // Memory wait acked after 5 frozen cycles.
    apply_reset();
    @(negedge clk_i);
    hz.mem_req_i = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("mw_state", hz.state_o, 2'd1);
    hz.mem_ack_i = 1'b1;
    step();
    check("mw_back_run", hz.state_o, 2'd0);
    check("mw_stall_cnt", hz.stall_cnt_o, 16'd5);
    drive_idle();

    // Memory never acks: timeout into sticky error.
    apply_reset();
    @(negedge clk_i);
    hz.mem_req_i = 1'b1;
    for (int i = 0; i < MEM_TIMEOUT; i++) step();
    check("to_state", hz.state_o, 2'd3);
    check("to_err", hz.err_o, 1'b1);
    hz.mem_req_i = 1'b0; hz.resume_i = 1'b1;
    step();
    check("to_resume_ignored", hz.state_o, 2'd3);
    hz.resume_i = 1'b0;
    apply_reset();
    @(negedge clk_i);

    // Debug halt from RUN: three drain cycles then HALTED, resume back to RUN.
    exp_q = {2'd0, 2'd2, 2'd2, 2'd2, 2'd3};
    for (int i = 0; i < 5; i++) begin
      check("halt_seq", hz.state_o, exp_q.pop_front());
      hz.halt_req_i = (i == 0);
      step();
    end
    hz.resume_i = 1'b1;
    step();
    check("halt_resumed", hz.state_o, 2'd0);
    drive_idle();

    // Reset mid-MEM_WAIT with a halt pending: no residual drain afterwards.
    hz.mem_req_i = 1'b1; hz.halt_req_i = 1'b1;
    step();
    hz.halt_req_i = 1'b0;
    step();
    apply_reset();
    @(negedge clk_i);
    step();
    step();
    check("rst_mw_no_pend", hz.state_o, 2'd0);

    // Reset mid-DRAIN.
    hz.halt_req_i = 1'b1;
    step();
    hz.halt_req_i = 1'b0;
    step();
    apply_reset();
    @(negedge clk_i);
    step();
    check("rst_drain_abandon", hz.state_o, 2'd0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        apply_reset();
        @(negedge clk_i);
      end
      drive_random();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
